// File: rtl/analog_scan_pkg.sv
// Shared defaults and helpers for the analog pin-scan capture path.
// Also used by the scan drivers so both sides agree on slot layout.
package analog_scan_pkg;

   localparam int NUM_PINS_DEF = 6;
   localparam int ADC_W_DEF    = 10;
   localparam int CNT_W_DEF    = 16;
   localparam int IDX_W        = $clog2(NUM_PINS_DEF);

   // Bit offset of slot k inside a packed frame of w-bit samples.
   function automatic int slot_lsb(input int k, input int w = ADC_W_DEF);
      return k * w;
   endfunction

endpackage

// File: rtl/analog_scan_capture_if.sv
// Sample-in / frame-out bus between the pin scan, the capture block and the host readout.
// master = stimulus/host side, slave = capture block.
interface analog_scan_capture_if
   import analog_scan_pkg::*;
#(
   parameter int NUM_PINS = NUM_PINS_DEF,
   parameter int DATA_W   = ADC_W_DEF,
   parameter int CNT_W    = CNT_W_DEF
);

   logic                         enable;
   logic [DATA_W-1:0]            sample_in;
   logic                         sample_valid;
   logic [NUM_PINS-1:0]          pin_sel;
   logic [NUM_PINS*DATA_W-1:0]   frame_out;
   logic                         frame_valid;
   logic                         frame_ready;
   logic                         overflow;
   logic                         clear_overflow;
   logic [CNT_W-1:0]             frame_count;

   modport master (
      output enable, sample_in, sample_valid, frame_ready, clear_overflow,
      input  pin_sel, frame_out, frame_valid, overflow, frame_count
   );

   modport slave (
      input  enable, sample_in, sample_valid, frame_ready, clear_overflow,
      output pin_sel, frame_out, frame_valid, overflow, frame_count
   );

endinterface

// File: rtl/pin_onehot_decode.sv
// Slot index to one-hot analog pin select, gated by the scan enable.
// Output is either exactly one-hot or all zero.
module pin_onehot_decode #(
   parameter int NUM_PINS = 6,
   parameter int IDX_W    = 3
) (
   input  logic [IDX_W-1:0]    idx_i,
   input  logic                enable_i,
   output logic [NUM_PINS-1:0] pin_sel_o
);

   assign pin_sel_o = enable_i ? (NUM_PINS'(1) << idx_i) : '0;

endmodule

// File: rtl/analog_scan_capture.sv
// Captures one sample per scan slot and presents each completed frame on a
// valid/ready register; frames arriving while the register is full are dropped.
module analog_scan_capture
   import analog_scan_pkg::*;
#(
   parameter int NUM_PINS = NUM_PINS_DEF,
   parameter int DATA_W   = ADC_W_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                  arduino_clk,
   input  logic                  reset,
   analog_scan_capture_if.slave  bus
);

   localparam int              IDXW     = $clog2(NUM_PINS);
   localparam int              FW       = NUM_PINS * DATA_W;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PINS - 1);

   logic [IDXW-1:0]  idx_q, idx_d;
   logic [FW-1:0]    buf_q, buf_d;
   logic [FW-1:0]    frame_q, frame_d;
   logic [FW-1:0]    cand;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] frame_count_q, frame_count_d;
   logic             accept, complete, load;

   pin_onehot_decode #(
      .NUM_PINS (NUM_PINS),
      .IDX_W    (IDXW)
   ) u_decode (
      .idx_i     (idx_q),
      .enable_i  (bus.enable),
      .pin_sel_o (bus.pin_sel)
   );

   always_comb begin
      accept   = bus.enable & bus.sample_valid;
      complete = accept & (idx_q == LAST_IDX);
      load     = complete & (~valid_q | bus.frame_ready);

      // Last slot bypasses the buffer so the frame is ready the cycle after its final sample.
      cand = buf_q;
      cand[slot_lsb(NUM_PINS - 1, DATA_W) +: DATA_W] = bus.sample_in;

      idx_d = idx_q;
      buf_d = buf_q;
      if (accept) begin
         buf_d[slot_lsb(int'(idx_q), DATA_W) +: DATA_W] = bus.sample_in;
         idx_d = complete ? '0 : idx_q + IDXW'(1);
      end

      frame_d = load ? cand : frame_q;

      valid_d = valid_q;
      if (load)
         valid_d = 1'b1;
      else if (valid_q & bus.frame_ready)
         valid_d = 1'b0;

      // A drop in the same cycle as a clear must leave the flag set.
      ovf_d = ovf_q;
      if (complete & ~load)
         ovf_d = 1'b1;
      else if (bus.clear_overflow)
         ovf_d = 1'b0;

      frame_count_d = frame_count_q + CNT_W'(load);
   end

   always_ff @(posedge arduino_clk) begin
      if (reset) begin
         idx_q         <= '0;
         buf_q         <= '0;
         frame_q       <= '0;
         valid_q       <= 1'b0;
         ovf_q         <= 1'b0;
         frame_count_q <= '0;
      end else begin
         idx_q         <= idx_d;
         buf_q         <= buf_d;
         frame_q       <= frame_d;
         valid_q       <= valid_d;
         ovf_q         <= ovf_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign bus.frame_out   = frame_q;
   assign bus.frame_valid = valid_q;
   assign bus.overflow    = ovf_q;
   assign bus.frame_count = frame_count_q;

endmodule
